// File: rtl/line_mem_pkg.sv
// Shared constants and types for the line memory responder.
//   LAT_DEFAULT / AW_DEFAULT / DW_DEFAULT : parameter defaults
//   CNT_W                                 : latency counter width
//   state_t                               : responder FSM states
package line_mem_pkg;

    localparam int unsigned LAT_DEFAULT = 4;
    localparam int unsigned AW_DEFAULT  = 14;
    localparam int unsigned DW_DEFAULT  = 64;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/line_mem_array.sv
// Line storage: 2^AW lines of DW bits, no reset.
//   clk     : write clock
//   we      : write enable
//   waddr   : write line address
//   wdata   : write line data
//   raddr   : read line address
//   rdata_c : combinational read data at raddr
module line_mem_array #(
    parameter int unsigned AW = 14,
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata_c
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Synchronous write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/line_mem_responder.sv
// Fixed-latency single-outstanding line memory responder.
//   clk, rst : clock, asynchronous active-high reset
//   re, we   : read / write request, held by initiator until rdy
//   addr     : line address, sampled at acceptance
//   wdata    : write line, sampled at acceptance
//   rd_data  : last completed read line
//   rdy      : one-cycle completion pulse, LAT cycles after acceptance
//   err      : one-cycle pulse with rdy when re and we were both high
//   busy     : high from acceptance through the rdy cycle
module line_mem_responder
    import line_mem_pkg::*;
#(
    parameter int unsigned LAT = LAT_DEFAULT,
    parameter int unsigned AW  = AW_DEFAULT,
    parameter int unsigned DW  = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          re,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rd_data,
    output logic          rdy,
    output logic          err,
    output logic          busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 2);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic             op_write;
    logic             op_both;
    logic             accept_c;
    logic             read_done_c;
    logic             mem_we_c;
    logic [DW-1:0]    mem_rdata_c;

    line_mem_array #(
        .AW (AW),
        .DW (DW)
    ) u_array (
        .clk     (clk),
        .we      (mem_we_c),
        .waddr   (addr_q),
        .wdata   (wdata_q),
        .raddr   (addr_q),
        .rdata_c (mem_rdata_c)
    );

    // Next-state, counter and strobe decode.
    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        accept_c    = 1'b0;
        read_done_c = 1'b0;
        mem_we_c    = 1'b0;
        case (state)
            IDLE: begin
                if (re || we) begin
                    next_state = BUSY;
                    next_cnt   = CNT_LOAD;
                    accept_c   = 1'b1;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    next_state  = DONE;
                    read_done_c = !op_write;
                end else begin
                    next_cnt = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                next_state = IDLE;
                mem_we_c   = op_write;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Request capture; write wins when both requests are high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            op_write <= 1'b0;
            op_both  <= 1'b0;
        end else if (accept_c) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            op_write <= we;
            op_both  <= re && we;
        end
    end

    // Output registers; the rdy/err pulse lands on the DONE -> IDLE edge so
    // busy covers acceptance through the pulse cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            rdy     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            rdy  <= (state == DONE);
            err  <= (state == DONE) && op_both;
            busy <= (next_state != IDLE) || (state == DONE);
            if (read_done_c) begin
                rd_data <= mem_rdata_c;
            end
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder (LAT 4 and LAT 2 instances).
module tb_line_mem_responder;

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          re, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd_data;
    logic          rdy, err, busy;

    logic          re2, we2;
    logic [AW-1:0] addr2;
    logic [DW-1:0] wdata2;
    logic [DW-1:0] rd_data2;
    logic          rdy2, err2, busy2;

    int tests_run = 0;
    int fails     = 0;

    // Reference model: array contents and last completed read line.
    logic [DW-1:0] model [logic [AW-1:0]];
    logic [DW-1:0] last_rd;

    always #5 clk = ~clk;

    line_mem_responder #(.LAT(4), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .wdata(wdata),
        .rd_data(rd_data), .rdy(rdy), .err(err), .busy(busy)
    );

    line_mem_responder #(.LAT(2), .AW(AW), .DW(DW)) dut2 (
        .clk(clk), .rst(rst), .re(re2), .we(we2), .addr(addr2), .wdata(wdata2),
        .rd_data(rd_data2), .rdy(rdy2), .err(err2), .busy(busy2)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rand_line();
        return {32'($urandom), 32'($urandom)};
    endfunction

    // Drive one request on the LAT-4 instance and observe its completion.
    // lat counts rising edges after the acceptance edge (-1 = never).
    task automatic run_txn(input logic r, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output int lat, output logic e,
                           output logic [DW-1:0] rdat, output logic [DW-1:0] rdat_after,
                           output logic rdy_after, output int busy_cnt);
        re = r; we = w; addr = a; wdata = d;
        lat = -1; e = 1'b0; rdat = '0; busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            if (rdy) begin
                lat = i; e = err; rdat = rd_data;
                break;
            end
        end
        re = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        if (busy) busy_cnt++;
        rdat_after = rd_data;
        rdy_after  = rdy;
    endtask

    task automatic test_reset();
        rst = 1'b1; re = 0; we = 0; addr = '0; wdata = '0;
        re2 = 0; we2 = 0; addr2 = '0; wdata2 = '0;
        last_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({rdy, err, busy} !== 3'b000) begin
            fails++; $display("FAIL reset_flags: got %b expected 000", {rdy, err, busy});
        end
        tests_run++;
        if (rd_data !== '0) begin
            fails++; $display("FAIL reset_rd_data: got %h expected 0", rd_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        int lat, bc; logic e, ra; logic [DW-1:0] rd, rda;
        logic [DW-1:0] d = 64'h1111_2222_3333_4444;
        // Request raised in the same step as reset release: first edge accepts.
        run_txn(1'b0, 1'b1, 14'h0010, d, lat, e, rd, rda, ra, bc);
        model[14'h0010] = d;
        tests_run++;
        if (lat !== 4) begin fails++; $display("FAIL wr_latency: got %0d expected 4", lat); end
        tests_run++;
        if (e !== 1'b0 || ra !== 1'b0) begin
            fails++; $display("FAIL wr_err_rdy_pulse: err %b rdy_after %b expected 0 0", e, ra);
        end
        tests_run++;
        if (bc !== 5) begin fails++; $display("FAIL wr_busy_cycles: got %0d expected 5", bc); end
        tests_run++;
        if (rd !== '0) begin fails++; $display("FAIL wr_rd_data_kept: got %h expected 0", rd); end

        run_txn(1'b1, 1'b0, 14'h0010, rand_line(), lat, e, rd, rda, ra, bc);
        last_rd = d;
        tests_run++;
        if (lat !== 4) begin fails++; $display("FAIL rd_latency: got %0d expected 4", lat); end
        tests_run++;
        if (rd !== d) begin fails++; $display("FAIL rd_data: got %h expected %h", rd, d); end
        tests_run++;
        if (rda !== d) begin fails++; $display("FAIL rd_data_held: got %h expected %h", rda, d); end
    endtask

    task automatic test_back_to_back();
        int lat, bc, lat1, lat2; logic e, ra; logic [DW-1:0] rd, rda, r1, r2;
        logic busy_gap;
        for (int k = 1; k <= 2; k++) begin
            logic [DW-1:0] d = rand_line();
            run_txn(1'b0, 1'b1, AW'(k), d, lat, e, rd, rda, ra, bc);
            model[AW'(k)] = d;
        end
        re = 1'b1; addr = 14'h0001;
        lat1 = -1; r1 = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) addr = 14'h0002;
            if (rdy) begin lat1 = i; r1 = rd_data; break; end
        end
        lat2 = -1; r2 = '0; busy_gap = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk); #1;
            if (j == 0) busy_gap = busy;
            if (rdy) begin lat2 = j; r2 = rd_data; break; end
        end
        re = 1'b0;
        @(posedge clk); #1;
        last_rd = model[14'h0002];
        tests_run++;
        if (lat1 !== 4 || r1 !== model[14'h0001]) begin
            fails++; $display("FAIL b2b_first: lat %0d data %h expected 4 %h", lat1, r1, model[14'h0001]);
        end
        tests_run++;
        if (busy_gap !== 1'b1) begin fails++; $display("FAIL b2b_busy_gap: got %b expected 1", busy_gap); end
        tests_run++;
        if (lat2 !== 4 || r2 !== model[14'h0002]) begin
            fails++; $display("FAIL b2b_second: lat %0d data %h expected 4 %h", lat2, r2, model[14'h0002]);
        end
    endtask

    task automatic test_err();
        int lat, bc; logic e, ra; logic [DW-1:0] rd, rda;
        logic [DW-1:0] d = 64'hDEAD_BEEF_0000_0001;
        run_txn(1'b1, 1'b1, 14'h0020, d, lat, e, rd, rda, ra, bc);
        model[14'h0020] = d;
        tests_run++;
        if (lat !== 4 || e !== 1'b1) begin
            fails++; $display("FAIL err_with_rdy: lat %0d err %b expected 4 1", lat, e);
        end
        tests_run++;
        if (rd !== last_rd) begin fails++; $display("FAIL err_rd_data_kept: got %h expected %h", rd, last_rd); end
        run_txn(1'b1, 1'b0, 14'h0020, '0, lat, e, rd, rda, ra, bc);
        last_rd = d;
        tests_run++;
        if (rd !== d || e !== 1'b0) begin
            fails++; $display("FAIL err_readback: data %h err %b expected %h 0", rd, e, d);
        end
    endtask

    task automatic test_random();
        int lat, bc; logic e, ra; logic [DW-1:0] rd, rda, d, exp_rd;
        logic [AW-1:0] a;
        for (int k = 0; k < 8; k++) begin
            d = rand_line();
            run_txn(1'b0, 1'b1, AW'(14'h0100 + k), d, lat, e, rd, rda, ra, bc);
            model[AW'(14'h0100 + k)] = d;
        end
        for (int n = 0; n < 24; n++) begin
            int op = int'($urandom_range(0, 2));
            a = AW'(14'h0100 + $urandom_range(0, 7));
            d = rand_line();
            if (op == 0) begin
                exp_rd = model[a];
            end else begin
                exp_rd = last_rd;
            end
            run_txn(op != 1, op != 0, a, d, lat, e, rd, rda, ra, bc);
            if (op == 0) last_rd = model[a];
            else         model[a] = d;
            tests_run++;
            if (lat !== 4 || e !== (op == 2) || ra !== 1'b0 || bc !== 5) begin
                fails++;
                $display("FAIL rand_ctrl[%0d]: lat %0d err %b rdy_after %b busy %0d expected 4 %b 0 5",
                         n, lat, e, ra, bc, op == 2);
            end
            tests_run++;
            if (rd !== exp_rd) begin
                fails++; $display("FAIL rand_data[%0d]: got %h expected %h", n, rd, exp_rd);
            end
        end
    endtask

    task automatic test_reset_abort();
        int lat, bc, rdy_seen; logic e, ra; logic [DW-1:0] rd, rda;
        logic [DW-1:0] prev = rand_line() | 64'h1;
        run_txn(1'b0, 1'b1, 14'h0030, prev, lat, e, rd, rda, ra, bc);
        model[14'h0030] = prev;
        run_txn(1'b1, 1'b0, 14'h0030, '0, lat, e, rd, rda, ra, bc);
        last_rd = prev;
        we = 1'b1; addr = 14'h0030; wdata = ~prev;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({rdy, busy} !== 2'b00 || rd_data !== '0) begin
            fails++; $display("FAIL abort_async: rdy %b busy %b rd_data %h expected 0 0 0", rdy, busy, rd_data);
        end
        last_rd = '0;
        we = 1'b0;
        rdy_seen = 0;
        repeat (2) begin @(posedge clk); #1; if (rdy) rdy_seen++; end
        rst = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (rdy) rdy_seen++; end
        tests_run++;
        if (rdy_seen !== 0) begin fails++; $display("FAIL abort_no_rdy: got %0d pulses expected 0", rdy_seen); end
        run_txn(1'b1, 1'b0, 14'h0030, '0, lat, e, rd, rda, ra, bc);
        last_rd = prev;
        tests_run++;
        if (lat !== 4 || rd !== prev) begin
            fails++; $display("FAIL abort_no_write: lat %0d data %h expected 4 %h", lat, rd, prev);
        end
    endtask

    task automatic test_lat2();
        int wl, r1, r2, cnt; logic [DW-1:0] d, rdv; logic e_any;
        d = rand_line();
        we2 = 1'b1; addr2 = 14'h0005; wdata2 = d;
        wl = -1; e_any = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rdy2) begin wl = i; e_any = err2; break; end
        end
        // Switch straight to a held read in the pulse cycle.
        we2 = 1'b0; re2 = 1'b1;
        r1 = -1; r2 = -1; cnt = 0; rdv = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (rdy2) begin
                if (cnt == 0) begin r1 = k; rdv = rd_data2; end
                else begin r2 = k; break; end
                cnt++;
            end
        end
        re2 = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (wl !== 2 || e_any !== 1'b0) begin
            fails++; $display("FAIL lat2_write: lat %0d err %b expected 2 0", wl, e_any);
        end
        tests_run++;
        if (r1 !== 2 || rdv !== d) begin
            fails++; $display("FAIL lat2_read: lat %0d data %h expected 2 %h", r1, rdv, d);
        end
        tests_run++;
        if (r2 !== 5) begin fails++; $display("FAIL lat2_spacing: second rdy at %0d expected 5", r2); end
        tests_run++;
        if (busy2 !== 1'b0) begin fails++; $display("FAIL lat2_idle_busy: got %b expected 0", busy2); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_err();
        test_random();
        test_reset_abort();
        test_lat2();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
